// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
// Shared types and constants for the MIPS core's instruction-memory loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  // Loader sequencing states; CHECK and ERROR are only reachable when the
  // checksum feature is compiled in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  localparam int IMEM_DEPTH_BYTES = 256;

  // All-zero word decodes as sll $0,$0,0, i.e. a NOP.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Big-endian byte lane extraction: lane 0 is the most significant byte.
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    be_byte = word[31:24];
      2'd1:    be_byte = word[23:16];
      2'd2:    be_byte = word[15:8];
      default: be_byte = word[7:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/loader_checksum.sv
// ============================================================================
// loader_checksum
// 32-bit modulo-2^32 running sum of accepted program words, with a
// synchronous clear and a combinational compare against a candidate word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_checksum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        add_en_i,
  input  logic [31:0] add_data_i,
  input  logic [31:0] cmp_data_i,
  output logic        match_o
);

  logic [31:0] sum_q;

  // Accumulate each accepted word; a new load starts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      sum_q <= 32'd0;
    end else if (add_en_i) begin
      sum_q <= sum_q + add_data_i;
    end
  end

  assign match_o = (sum_q == cmp_data_i);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader
// Writer side of the core's byte-array instruction memory. Accepts 32-bit
// program words over a valid/ready stream, stores them big-endian and holds
// the core in reset until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// checksum word (sum of program words mod 2^32) before the core is released.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH_BYTES = IMEM_DEPTH_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  instruction_mem [DEPTH_BYTES-1:0],
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [6:0]  words_loaded
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int AW    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  loader_state_t              state_q;
  logic [DEPTH_BYTES-1:0][7:0] mem_q;
  logic [6:0]                 words_q;
  logic                       in_ready_q;
  logic                       core_reset_q;
  logic                       load_done_q;

  logic          w_xfer;
  logic          w_can_start;
  logic          w_start_accept;
  logic          w_image_end;
  logic [AW-1:0] w_base;

  // in_ready is a pure register, so a transfer is valid AND the registered ready.
  assign w_xfer         = in_valid && in_ready_q;
  assign w_can_start    = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);
  assign w_start_accept = start && w_can_start;
  // The image ends on an explicit last word or when the array is full;
  // anything beyond capacity is simply never accepted.
  assign w_image_end    = in_last || (words_q == 7'(WORDS - 1));
  // Word k lives at byte address 4k; only meaningful while words_q < WORDS.
  assign w_base         = AW'({words_q, 2'b00});

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic load_error_q;
  logic w_sum_match;

  loader_checksum u_checksum (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (w_start_accept),
    .add_en_i   (w_xfer && (state_q == LOAD)),
    .add_data_i (in_data),
    .cmp_data_i (in_data),
    .match_o    (w_sum_match)
  );

  assign load_error = load_error_q;
`else
  assign load_error = 1'b0;
`endif

  // Loader FSM: sequencing, memory writes and all registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_q        <= {WORDS{NOP_WORD}};
      words_q      <= 7'd0;
      in_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      load_error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            // Clearing together with the core_reset rise means the core
            // never runs on a half-old, half-new image.
            state_q      <= LOAD;
            mem_q        <= {WORDS{NOP_WORD}};
            words_q      <= 7'd0;
            in_ready_q   <= 1'b1;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            load_error_q <= 1'b0;
`endif
          end
        end

        LOAD: begin
          if (w_xfer) begin
            mem_q[w_base]           <= be_byte(in_data, 2'd0);
            mem_q[w_base + AW'(1)]  <= be_byte(in_data, 2'd1);
            mem_q[w_base + AW'(2)]  <= be_byte(in_data, 2'd2);
            mem_q[w_base + AW'(3)]  <= be_byte(in_data, 2'd3);
            words_q                 <= words_q + 7'd1;
            if (w_image_end) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              // Stay ready: the next transfer is the checksum word.
              state_q      <= CHECK;
`else
              state_q      <= DONE;
              in_ready_q   <= 1'b0;
              core_reset_q <= 1'b0;
              load_done_q  <= 1'b1;
`endif
            end
          end
        end

        CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_xfer) begin
            in_ready_q <= 1'b0;
            if (w_sum_match) begin
              state_q      <= DONE;
              core_reset_q <= 1'b0;
              load_done_q  <= 1'b1;
            end else begin
              state_q      <= ERROR;
              load_error_q <= 1'b1;
            end
          end
`endif
        end

        default: ;
      endcase
    end
  end

  for (genvar b = 0; b < DEPTH_BYTES; b++) begin : g_mem_out
    assign instruction_mem[b] = mem_q[b];
  end

  assign in_ready     = in_ready_q;
  assign core_reset   = core_reset_q;
  assign load_done    = load_done_q;
  assign words_loaded = words_q;

endmodule

`default_nettype wire
